// File: rtl/grf_wb_port_pkg.sv
// ---------------------------------------------------------------------------
// grf_wb_port_pkg
//   Shared definitions for the general register file / writeback port.
//   - REG_ZERO, REG_RA : well-known register numbers ($0, $ra)
//   - GRF_DEPTH        : architectural register count
//   - rd_src_e         : source selected by a read port
//   - rd_src_sel()     : read-port priority (zero > bypass > array)
// ---------------------------------------------------------------------------
package grf_wb_port_pkg;

   localparam logic [4:0] REG_ZERO  = 5'd0;
   localparam logic [4:0] REG_RA    = 5'd31;
   localparam int         GRF_DEPTH = 32;

   typedef enum logic [1:0] {
      RD_SRC_ZERO   = 2'd0,
      RD_SRC_BYPASS = 2'd1,
      RD_SRC_ARRAY  = 2'd2
   } rd_src_e;

   // $0 always wins; a same-cycle write to the addressed register is
   // forwarded ahead of the (still stale) array contents.
   function automatic rd_src_e rd_src_sel(input logic addr_is_zero,
                                          input logic wr_hit);
      rd_src_e src;
      if (addr_is_zero) begin
         src = RD_SRC_ZERO;
      end else if (wr_hit) begin
         src = RD_SRC_BYPASS;
      end else begin
         src = RD_SRC_ARRAY;
      end
      return src;
   endfunction

endpackage

// File: rtl/grf_wb_port_read_mux.sv
// ---------------------------------------------------------------------------
// grf_read_mux
//   Combinational select for one register-file read port.
//   Ports:
//     rd_addr_i   : register number being read
//     wr_en_i     : W-stage write enable
//     wr_addr_i   : W-stage write register number
//     wr_data_i   : W-stage write data
//     arr_data_i  : array contents at rd_addr_i
//     rd_data_o   : selected read data
// ---------------------------------------------------------------------------
module grf_read_mux
   import grf_wb_port_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] rd_addr_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [DATA_W-1:0] arr_data_i,
   output logic [DATA_W-1:0] rd_data_o
);

   rd_src_e src;

   always_comb begin
      src = rd_src_sel(rd_addr_i == '0, wr_en_i && (wr_addr_i == rd_addr_i));
      rd_data_o = '0;
      case (src)
         RD_SRC_ZERO:   rd_data_o = '0;
         RD_SRC_BYPASS: rd_data_o = wr_data_i;
         RD_SRC_ARRAY:  rd_data_o = arr_data_i;
         default:       rd_data_o = '0;
      endcase
   end

endmodule

// File: rtl/grf_wb_port.sv
// ---------------------------------------------------------------------------
// grf_wb_port
//   General register file at the consuming end of the W-stage write
//   interface, plus a one-entry commit trace and retired-write counter.
//   Ports:
//     clk, reset      : clock, asynchronous active-low reset
//     A1, A2          : D-stage read addresses
//     RD1, RD2        : combinational read data (with W->D bypass)
//     A3, WD, RegWrite: W-stage write address / data / enable
//     WPC             : PC of the W-stage instruction (trace only)
//     trace_valid     : pulses for one cycle after each commit edge
//     trace_pc/reg/data : fields of the most recent commit
//     wr_count        : number of commits since reset (wraps)
// ---------------------------------------------------------------------------
module grf_wb_port
   import grf_wb_port_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] A1,
   input  logic [ADDR_W-1:0] A2,
   output logic [DATA_W-1:0] RD1,
   output logic [DATA_W-1:0] RD2,
   input  logic [ADDR_W-1:0] A3,
   input  logic [DATA_W-1:0] WD,
   input  logic              RegWrite,
   input  logic [31:0]       WPC,
   output logic              trace_valid,
   output logic [31:0]       trace_pc,
   output logic [ADDR_W-1:0] trace_reg,
   output logic [DATA_W-1:0] trace_data,
   output logic [CNT_W-1:0]  wr_count
);

   localparam int             DEPTH   = 1 << ADDR_W;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [DATA_W-1:0] regs_q [DEPTH];

   logic              tvalid_q, tvalid_d;
   logic [31:0]       tpc_q,    tpc_d;
   logic [ADDR_W-1:0] treg_q,   treg_d;
   logic [DATA_W-1:0] tdata_q,  tdata_d;
   logic [CNT_W-1:0]  cnt_q,    cnt_d;

   // Writes to $0 are dropped entirely: no array update, trace or count.
   logic commit;
   assign commit = RegWrite && (A3 != '0);

   // Register array. Entry 0 is cleared by reset and never written, so it
   // stays zero; the read muxes also force $0 reads to zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
      end else if (commit) begin
         regs_q[A3] <= WD;
      end
   end

   always_comb begin
      tvalid_d = commit;
      tpc_d    = tpc_q;
      treg_d   = treg_q;
      tdata_d  = tdata_q;
      cnt_d    = cnt_q;
      if (commit) begin
         tpc_d   = WPC;
         treg_d  = A3;
         tdata_d = WD;
         cnt_d   = cnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tvalid_q <= 1'b0;
         tpc_q    <= '0;
         treg_q   <= '0;
         tdata_q  <= '0;
         cnt_q    <= '0;
      end else begin
         tvalid_q <= tvalid_d;
         tpc_q    <= tpc_d;
         treg_q   <= treg_d;
         tdata_q  <= tdata_d;
         cnt_q    <= cnt_d;
      end
   end

   grf_read_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd1 (
      .rd_addr_i  (A1),
      .wr_en_i    (RegWrite),
      .wr_addr_i  (A3),
      .wr_data_i  (WD),
      .arr_data_i (regs_q[A1]),
      .rd_data_o  (RD1)
   );

   grf_read_mux #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_rd2 (
      .rd_addr_i  (A2),
      .wr_en_i    (RegWrite),
      .wr_addr_i  (A3),
      .wr_data_i  (WD),
      .arr_data_i (regs_q[A2]),
      .rd_data_o  (RD2)
   );

   assign trace_valid = tvalid_q;
   assign trace_pc    = tpc_q;
   assign trace_reg   = treg_q;
   assign trace_data  = tdata_q;
   assign wr_count    = cnt_q;

endmodule

// File: tb/tb_grf_wb_port.sv
module tb_grf_wb_port;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  A1, A2, A3;
   logic [31:0] WD, WPC;
   logic        RegWrite;
   logic [31:0] RD1, RD2;
   logic        trace_valid;
   logic [31:0] trace_pc;
   logic [4:0]  trace_reg;
   logic [31:0] trace_data;
   logic [31:0] wr_count;

   // second instance with a narrow counter for the wrap check
   logic [4:0]  a3_4;
   logic [31:0] wd_4;
   logic        rw_4;
   logic [31:0] rd1_4, rd2_4;
   logic        tv_4;
   logic [31:0] tpc_4;
   logic [4:0]  treg_4;
   logic [31:0] tdata_4;
   logic [3:0]  cnt_4;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   grf_wb_port #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
      .A3(A3), .WD(WD), .RegWrite(RegWrite), .WPC(WPC),
      .trace_valid(trace_valid), .trace_pc(trace_pc), .trace_reg(trace_reg),
      .trace_data(trace_data), .wr_count(wr_count)
   );

   grf_wb_port #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .A1(5'd0), .A2(5'd0), .RD1(rd1_4), .RD2(rd2_4),
      .A3(a3_4), .WD(wd_4), .RegWrite(rw_4), .WPC(32'h0000_4000),
      .trace_valid(tv_4), .trace_pc(tpc_4), .trace_reg(treg_4),
      .trace_data(tdata_4), .wr_count(cnt_4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " trace_valid"}, {31'd0, trace_valid}, 32'd0);
      chk({tag, " trace_pc"},    trace_pc, 32'd0);
      chk({tag, " trace_reg"},   {27'd0, trace_reg}, 32'd0);
      chk({tag, " trace_data"},  trace_data, 32'd0);
      chk({tag, " wr_count"},    wr_count, 32'd0);
   endtask

   typedef struct {
      logic        rw;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] wpc;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [31:0] e_rd1;
      logic [31:0] e_rd2;
      logic        e_tv;
      logic [31:0] e_tpc;
      logic [4:0]  e_treg;
      logic [31:0] e_tdata;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl [10];

   // behavioural model: architectural state as plain arrays/variables
   logic [31:0] m_regs [32];
   logic        m_tv;
   logic [31:0] m_tpc, m_tdata, m_cnt;
   logic [4:0]  m_treg;

   function automatic logic [31:0] m_read(input logic [4:0] a, input logic rw,
                                          input logic [4:0] wa, input logic [31:0] wd);
      if (a == 5'd0) return 32'd0;
      if (rw && wa == a) return wd;
      return m_regs[a];
   endfunction

   initial begin
      tbl[0] = '{1'b1, 5'd5,  32'h1234_5678, 32'h3000, 5'd5,  5'd0,  32'h1234_5678, 32'h0,
                 1'b1, 32'h3000, 5'd5,  32'h1234_5678, 32'd1};
      tbl[1] = '{1'b0, 5'd5,  32'h0,         32'h3004, 5'd5,  5'd5,  32'h1234_5678, 32'h1234_5678,
                 1'b0, 32'h3000, 5'd5,  32'h1234_5678, 32'd1};
      tbl[2] = '{1'b1, 5'd0,  32'hFFFF_FFFF, 32'h3008, 5'd0,  5'd5,  32'h0,         32'h1234_5678,
                 1'b0, 32'h3000, 5'd5,  32'h1234_5678, 32'd1};
      tbl[3] = '{1'b1, 5'd8,  32'hAAAA_AAAA, 32'h300C, 5'd8,  5'd8,  32'hAAAA_AAAA, 32'hAAAA_AAAA,
                 1'b1, 32'h300C, 5'd8,  32'hAAAA_AAAA, 32'd2};
      tbl[4] = '{1'b1, 5'd8,  32'h5555_5555, 32'h3010, 5'd8,  5'd8,  32'h5555_5555, 32'h5555_5555,
                 1'b1, 32'h3010, 5'd8,  32'h5555_5555, 32'd3};
      tbl[5] = '{1'b0, 5'd8,  32'h0,         32'h3014, 5'd8,  5'd5,  32'h5555_5555, 32'h1234_5678,
                 1'b0, 32'h3010, 5'd8,  32'h5555_5555, 32'd3};
      tbl[6] = '{1'b1, 5'd31, 32'h1,         32'h3018, 5'd31, 5'd0,  32'h1,         32'h0,
                 1'b1, 32'h3018, 5'd31, 32'h1,         32'd4};
      tbl[7] = '{1'b1, 5'd31, 32'h2,         32'h301C, 5'd31, 5'd31, 32'h2,         32'h2,
                 1'b1, 32'h301C, 5'd31, 32'h2,         32'd5};
      tbl[8] = '{1'b0, 5'd0,  32'h0,         32'h3020, 5'd31, 5'd8,  32'h2,         32'h5555_5555,
                 1'b0, 32'h301C, 5'd31, 32'h2,         32'd5};
      tbl[9] = '{1'b1, 5'd9,  32'hDEAD_BEEF, 32'h3024, 5'd9,  5'd10, 32'hDEAD_BEEF, 32'h0,
                 1'b1, 32'h3024, 5'd9,  32'hDEAD_BEEF, 32'd6};

      reset = 1'b0; RegWrite = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0; WPC = '0;
      rw_4 = 1'b0; a3_4 = '0; wd_4 = '0;

      // reset state
      #2;
      chk_all_zero("por");
      #10 reset = 1'b1;
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         A1 = 5'(i); A2 = 5'(31 - i);
         #1;
         chk($sformatf("post-reset RD1[%0d]", i), RD1, 32'd0);
         chk($sformatf("post-reset RD2[%0d]", 31 - i), RD2, 32'd0);
      end

      // directed table
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         RegWrite = tbl[i].rw; A3 = tbl[i].a3; WD = tbl[i].wd; WPC = tbl[i].wpc;
         A1 = tbl[i].a1; A2 = tbl[i].a2;
         #1;
         chk($sformatf("tbl%0d RD1", i), RD1, tbl[i].e_rd1);
         chk($sformatf("tbl%0d RD2", i), RD2, tbl[i].e_rd2);
         @(posedge clk);
         #1;
         chk($sformatf("tbl%0d trace_valid", i), {31'd0, trace_valid}, {31'd0, tbl[i].e_tv});
         chk($sformatf("tbl%0d trace_pc", i), trace_pc, tbl[i].e_tpc);
         chk($sformatf("tbl%0d trace_reg", i), {27'd0, trace_reg}, {27'd0, tbl[i].e_treg});
         chk($sformatf("tbl%0d trace_data", i), trace_data, tbl[i].e_tdata);
         chk($sformatf("tbl%0d wr_count", i), wr_count, tbl[i].e_cnt);
      end

      // asynchronous reset pulse between edges clears everything at once
      @(negedge clk);
      RegWrite = 1'b0; A1 = 5'd9; A2 = 5'd31;
      #2 reset = 1'b0;
      #1;
      chk_all_zero("async");
      chk("async RD1 r9", RD1, 32'd0);
      chk("async RD2 r31", RD2, 32'd0);
      #1 reset = 1'b1;

      // commit attempted on an edge while reset is held is ignored
      @(negedge clk);
      RegWrite = 1'b1; A3 = 5'd12; WD = 32'hCAFE_F00D; WPC = 32'h3100;
      reset = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      RegWrite = 1'b0; A1 = 5'd12; A2 = 5'd12;
      #1;
      chk("rst-edge RD1 r12", RD1, 32'd0);
      chk_all_zero("rst-edge");

      // randomized run against the model
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_tv = 1'b0; m_tpc = '0; m_treg = '0; m_tdata = '0; m_cnt = '0;
      for (int i = 0; i < 400; i++) begin
         logic [4:0] a3r;
         @(negedge clk);
         RegWrite = ($urandom_range(0, 3) != 0);
         a3r = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
         A3  = a3r;
         WD  = $urandom;
         WPC = $urandom;
         A1  = ($urandom_range(0, 1) == 0) ? a3r : 5'($urandom_range(0, 31));
         A2  = ($urandom_range(0, 2) == 0) ? a3r : 5'($urandom_range(0, 31));
         #1;
         chk("rnd RD1", RD1, m_read(A1, RegWrite, A3, WD));
         chk("rnd RD2", RD2, m_read(A2, RegWrite, A3, WD));
         if (RegWrite && A3 != 5'd0) begin
            m_regs[A3] = WD;
            m_tv = 1'b1; m_tpc = WPC; m_treg = A3; m_tdata = WD;
            m_cnt = m_cnt + 1;
         end else begin
            m_tv = 1'b0;
         end
         @(posedge clk);
         #1;
         chk("rnd trace_valid", {31'd0, trace_valid}, {31'd0, m_tv});
         chk("rnd trace_pc", trace_pc, m_tpc);
         chk("rnd trace_reg", {27'd0, trace_reg}, {27'd0, m_treg});
         chk("rnd trace_data", trace_data, m_tdata);
         chk("rnd wr_count", wr_count, m_cnt);
      end

      // final sweep of every register against the model
      @(negedge clk);
      RegWrite = 1'b0;
      for (int i = 0; i < 32; i++) begin
         A1 = 5'(i); A2 = 5'(i);
         #1;
         chk($sformatf("sweep RD1[%0d]", i), RD1, (i == 0) ? 32'd0 : m_regs[i]);
         chk($sformatf("sweep RD2[%0d]", i), RD2, (i == 0) ? 32'd0 : m_regs[i]);
      end

      // 4-bit counter wraps from all-ones to zero
      chk("wrap start", {28'd0, cnt_4}, 32'd0);
      for (int i = 1; i <= 16; i++) begin
         @(negedge clk);
         rw_4 = 1'b1; a3_4 = 5'((i % 31) + 1); wd_4 = 32'(i);
         @(posedge clk);
         #1;
         if (i == 15) chk("wrap all-ones", {28'd0, cnt_4}, 32'd15);
         if (i == 16) begin
            chk("wrap to zero", {28'd0, cnt_4}, 32'd0);
            chk("wrap trace_valid", {31'd0, tv_4}, 32'd1);
            chk("wrap trace_data", tdata_4, 32'd16);
         end
      end
      @(negedge clk);
      rw_4 = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
